l2_line_adapter: RTL and testbench

L2_LINE_ADAPTER -- requirements
Module: l2_line_adapter

---
 rtl/l2_pkg.sv | 13 +
 rtl/l2_line_adapter.sv | 91 +++++++++
 tb/tb_l2_line_adapter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/l2_pkg.sv
// Shared constants and FSM encoding for the L2 line <-> memory burst adapter.
package l2_pkg;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;
endpackage

// File: rtl/l2_line_adapter.sv
// Splits an L2 line write-back into a 4-beat memory burst and assembles a
// 4-beat memory read burst into an L2 fill line.
module l2_line_adapter #(
    parameter int LINE_W = l2_pkg::LINE_W,
    parameter int BEAT_W = l2_pkg::BEAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    output logic              resp_o,
    output logic [31:0]       address_o,
    output logic              read_o,
    output logic              write_o,
    output logic [BEAT_W-1:0] burst_o,
    input  logic [BEAT_W-1:0] burst_i,
    input  logic              resp_i
);
    import l2_pkg::*;

    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    state_t            state;
    logic [1:0]        cnt;
    logic [LINE_W-1:0] wbuf;
    logic [4:0]        unused_addr_lsb;

    assign unused_addr_lsb = address_i[4:0];

    // Write beat tracks the counter directly so memory sees beat k while cnt==k.
    assign burst_o = wbuf[int'(cnt)*BEAT_W +: BEAT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            wbuf      <= '0;
            line_o    <= '0;
            address_o <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_o <= 1'b0;
                    cnt    <= '0;
                    if (write_i) begin
                        state     <= WR_BURST;
                        write_o   <= 1'b1;
                        wbuf      <= line_i;
                        address_o <= {address_i[31:5], 5'b0};
                    end else if (read_i) begin
                        state     <= RD_BURST;
                        read_o    <= 1'b1;
                        address_o <= {address_i[31:5], 5'b0};
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        line_o[int'(cnt)*BEAT_W +: BEAT_W] <= burst_i;
                        cnt <= cnt + 2'd1;
                        if (cnt == LAST_BEAT) begin
                            state  <= DONE;
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                        end
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == LAST_BEAT) begin
                            state   <= DONE;
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    resp_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_line_adapter.sv
// Directed bench for l2_line_adapter: table of read/write transactions plus
// hand sequences for idle noise, read/write collision and mid-burst reset.
module tb_l2_line_adapter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  address_i;
    logic         read_i, write_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  address_o;
    logic         read_o, write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i;
    logic         resp_i;

    int checks = 0;
    int failures = 0;

    l2_line_adapter dut (
        .clk(clk), .rst_n(rst_n), .address_i(address_i), .read_i(read_i),
        .write_i(write_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
        .address_o(address_o), .read_o(read_o), .write_o(write_o),
        .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;      // fill data from memory, or write-back line
        logic [15:0]  pat;       // resp_i per burst cycle, 1 after plen
        int           plen;
        logic [31:0]  exp_addr;
        logic [255:0] exp_line;  // line_o after the transaction
    } vec_t;

    vec_t vecs[4];

    localparam logic [255:0] RD0 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] WR1 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                    64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    localparam logic [255:0] RD2 = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                                    64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
    localparam logic [255:0] WR3 = {64'h8765_4321_0FED_CBA9, 64'h0123_4567_89AB_CDEF,
                                    64'hFFFF_0000_FFFF_0000, 64'h5A5A_A5A5_5A5A_A5A5};
    localparam logic [255:0] WR4 = {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
                                    64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001};

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory returns read beats in order; the beat index follows the bench's own count.
    task automatic run_txn(input vec_t v);
        int beats;
        int cyc;
        @(negedge clk);
        address_i = v.addr; line_i = v.data; write_i = v.wr; read_i = !v.wr; resp_i = 1'b0;
        @(negedge clk);
        chk("address_o", 256'(address_o), 256'(v.exp_addr));
        chk("burst_req", 256'({read_o, write_o}), 256'(v.wr ? 2'b01 : 2'b10));
        address_i = ~v.addr; line_i = ~v.data;
        beats = 0; cyc = 0;
        while (beats < 4 && cyc < 40) begin
            resp_i  = (cyc < v.plen) ? v.pat[cyc] : 1'b1;
            burst_i = v.wr ? 64'hDEAD_DEAD_DEAD_DEAD : v.data[beats*64 +: 64];
            if (v.wr && resp_i) chk("burst_o", 256'(burst_o), 256'(v.data[beats*64 +: 64]));
            chk("req_level", 256'(v.wr ? write_o : read_o), 256'(1'b1));
            chk("resp_early", 256'(resp_o), 256'(1'b0));
            @(negedge clk);
            if (resp_i) beats++;
            cyc++;
        end
        chk("beats_done", 256'(beats), 256'(4));
        resp_i = 1'b0;
        chk("resp_pulse", 256'(resp_o), 256'(1'b1));
        chk("req_drop", 256'({read_o, write_o}), 256'(2'b00));
        read_i = 1'b0; write_i = 1'b0;
        @(negedge clk);
        chk("resp_single", 256'(resp_o), 256'(1'b0));
        chk("line_o", line_o, v.exp_line);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h1234_5678, RD0, 16'h0000, 0, 32'h1234_5660, RD0};
        vecs[1] = '{1'b1, 32'hDEAD_BEEF, WR1, 16'h0000, 0, 32'hDEAD_BEE0, RD0};
        // resp_i 1,0,0,1,0,1,1 (bit i = cycle i)
        vecs[2] = '{1'b0, 32'h0000_003F, RD2, 16'b110_1001, 7, 32'h0000_0020, RD2};
        // resp_i 0,1,1,0,1,0,1
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, WR3, 16'b101_0110, 7, 32'hFFFF_FFE0, RD2};

        rst_n = 1'b0; address_i = '0; read_i = 0; write_i = 0; line_i = '0;
        burst_i = '0; resp_i = 0;
        repeat (2) @(negedge clk);
        chk("rst_outs", 256'({resp_o, read_o, write_o}), 256'(3'b000));
        chk("rst_addr", 256'(address_o), 256'(0));
        chk("rst_line", line_o, 256'(0));
        chk("rst_wbuf", 256'(burst_o), 256'(0));
        rst_n = 1'b1;

        // resp_i noise in IDLE is ignored
        burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            resp_i = i[0] ? 1'b0 : 1'b1;
            @(negedge clk);
            chk("idle_noise", 256'({resp_o, read_o, write_o}), 256'(3'b000));
        end
        resp_i = 1'b0;
        chk("idle_line", line_o, 256'(0));

        foreach (vecs[i]) run_txn(vecs[i]);

        // read and write together: write wins, read_o never rises
        @(negedge clk);
        address_i = 32'h0000_1000; line_i = WR4; read_i = 1'b1; write_i = 1'b1;
        @(negedge clk);
        chk("both_wr", 256'({read_o, write_o}), 256'(2'b01));
        resp_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            chk("both_rd_low", 256'(read_o), 256'(1'b0));
            chk("both_burst", 256'(burst_o), 256'(WR4[b*64 +: 64]));
            @(negedge clk);
        end
        resp_i = 1'b0;
        chk("both_resp", 256'(resp_o), 256'(1'b1));
        read_i = 1'b0; write_i = 1'b0;
        @(negedge clk);
        chk("both_line", line_o, RD2);

        // reset after two read beats abandons the fill
        @(negedge clk);
        address_i = 32'h0000_2000; read_i = 1'b1;
        @(negedge clk);
        resp_i = 1'b1;
        burst_i = 64'h7777_7777_7777_7777;
        repeat (2) @(negedge clk);
        resp_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_rd", 256'({resp_o, read_o, write_o}), 256'(3'b000));
        chk("rst_mid_line", line_o, 256'(0));
        chk("rst_mid_addr", 256'(address_o), 256'(0));
        read_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_resp", 256'({resp_o, read_o}), 256'(2'b00));
        end
        run_txn(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
